// File: rtl/clock_gen_pkg.sv
// Shared helpers for the multi-channel NCO timebase.
// Increment math and channel-select width.
package clock_gen_pkg;

  function automatic logic [63:0] calc_inc(
    input int unsigned     width,
    input longint unsigned fin,
    input longint unsigned fout
  );
    logic [63:0] num;
    num = (64'd1 << width) * fout;
    return (num - 64'd1) / fin + 64'd1;
  endfunction

  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CHAN_W = chan_w(4);

endpackage

// File: rtl/nco_channel.sv
// One phase-accumulator channel with deferred
// increment update applied on the wrapping step.
module nco_channel
  import clock_gen_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] DEFAULT_INC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             pending_o,
  output logic             slow_clk_o,
  output logic             tick_o
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] inc_q, inc_d;
  logic [WIDTH-1:0] nxt_q, nxt_d;
  logic             pend_q, pend_d;
  logic             tick_q, tick_d;
  logic [WIDTH:0]   sum;

  assign sum = {1'b0, acc_q} + {1'b0, inc_q};

  always_comb begin
    acc_d  = acc_q;
    inc_d  = inc_q;
    nxt_d  = nxt_q;
    pend_d = pend_q;
    tick_d = 1'b0;
    if (sync_i) begin
      acc_d = '0;
      if (wr_i) begin
        inc_d  = wdata_i;
        pend_d = 1'b0;
      end else if (pend_q) begin
        inc_d  = nxt_q;
        pend_d = 1'b0;
      end
    end else begin
      if (en_i) begin
        acc_d  = sum[WIDTH-1:0];
        tick_d = sum[WIDTH];
        // swap rate only at a period boundary
        if (sum[WIDTH] && pend_q) begin
          inc_d  = nxt_q;
          pend_d = 1'b0;
        end
      end
      if (wr_i) begin
        nxt_d  = wdata_i;
        pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q  <= '0;
      inc_q  <= DEFAULT_INC;
      nxt_q  <= '0;
      pend_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      inc_q  <= inc_d;
      nxt_q  <= nxt_d;
      pend_q <= pend_d;
      tick_q <= tick_d;
    end
  end

  assign pending_o  = pend_q;
  assign slow_clk_o = acc_q[WIDTH-1];
  assign tick_o     = tick_q;

endmodule

// File: rtl/multi_nco_clock_gen.sv
// Multi-channel NCO clock/tick generator: config
// decode, ready mux and sync fan-out over channels.
module multi_nco_clock_gen
  import clock_gen_pkg::*;
#(
  parameter int          WIDTH            = 32,
  parameter int          CHANNELS         = 4,
  parameter longint      FREQ_IN          = 50000000,
  parameter longint      FREQ_OUT_DEFAULT = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [CHANNELS-1:0]           enable,
  input  logic                          sync,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [chan_w(CHANNELS)-1:0]   cfg_chan,
  input  logic [WIDTH-1:0]              cfg_inc,
  output logic [CHANNELS-1:0]           slow_clk,
  output logic [CHANNELS-1:0]           tick
);

  localparam int CW = chan_w(CHANNELS);

  typedef logic [WIDTH-1:0] inc_t;
  typedef logic [CW-1:0]    chan_t;

  localparam inc_t DEFAULT_INC = inc_t'(calc_inc(
    WIDTH, FREQ_IN, FREQ_OUT_DEFAULT));
  localparam logic [CW:0] NCH = (CW+1)'(CHANNELS);

  logic [CHANNELS-1:0] pend_w;
  logic [CHANNELS-1:0] wr;
  logic [2**CW-1:0]    pend_pad;
  logic                in_range;
  logic                accept;

  assign in_range = {1'b0, cfg_chan} < NCH;

  always_comb begin
    pend_pad = '0;
    pend_pad[CHANNELS-1:0] = pend_w;
  end

  // out-of-range writes are always accepted and dropped
  assign cfg_ready = in_range ? ~pend_pad[cfg_chan] : 1'b1;
  assign accept    = cfg_valid & cfg_ready & in_range;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign wr[i] = accept & (cfg_chan == chan_t'(i));

    nco_channel #(
      .WIDTH       (WIDTH),
      .DEFAULT_INC (DEFAULT_INC)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .en_i       (enable[i]),
      .sync_i     (sync),
      .wr_i       (wr[i]),
      .wdata_i    (cfg_inc),
      .pending_o  (pend_w[i]),
      .slow_clk_o (slow_clk[i]),
      .tick_o     (tick[i])
    );
  end

endmodule

// File: tb/tb_multi_nco_clock_gen.sv
// Directed bench for multi_nco_clock_gen at WIDTH=8,
// three channels (2-bit select) and FREQ_IN=256.
module tb_multi_nco_clock_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] enable;
  logic       sync;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_chan;
  logic [7:0] cfg_inc;
  logic [2:0] slow_clk;
  logic [2:0] tick;

  int checks = 0;
  int errors = 0;

  multi_nco_clock_gen #(
    .WIDTH            (8),
    .CHANNELS         (3),
    .FREQ_IN          (256),
    .FREQ_OUT_DEFAULT (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .sync      (sync),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_chan  (cfg_chan),
    .cfg_inc   (cfg_inc),
    .slow_clk  (slow_clk),
    .tick      (tick)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (slow_clk !== 3'b000) begin
      errors++;
      $display("FAIL rst_slow got %b want 000", slow_clk);
    end
    checks++;
    if (tick !== 3'b000) begin
      errors++;
      $display("FAIL rst_tick got %b want 000", tick);
    end
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready got %b want 1", cfg_ready);
    end
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int sc_e[8] = '{0, 1, 1, 0, 0, 1, 1, 0};
    int tk_e[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    sync = 1'b1; cfg_valid = 1'b1;
    cfg_chan = 2'd0; cfg_inc = 8'd64;
    step();
    sync = 1'b0; cfg_valid = 1'b0;
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL sync_wr_ready got %b want 1", cfg_ready);
    end
    enable = 3'b001;
    for (int k = 0; k < 8; k++) begin
      step();
      checks++;
      if (slow_clk[0] !== sc_e[k][0] || tick[0] !== tk_e[k][0]) begin
        errors++;
        $display("FAIL basic step %0d got sc=%b tk=%b want sc=%0d tk=%0d",
                 k + 1, slow_clk[0], tick[0], sc_e[k], tk_e[k]);
      end
    end
  endtask

  task automatic test_cfg_update();
    int sc_e[8] = '{0, 0, 0, 1, 1, 1, 1, 0};
    int tk_e[8] = '{0, 0, 0, 0, 0, 0, 0, 1};
    step();
    cfg_valid = 1'b1; cfg_chan = 2'd0; cfg_inc = 8'd32;
    #1;
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL upd_ready_pre got %b want 1", cfg_ready);
    end
    step();
    cfg_valid = 1'b0;
    checks++;
    if (cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL upd_ready_pend got %b want 0", cfg_ready);
    end
    step();
    checks++;
    if (cfg_ready !== 1'b0 || tick[0] !== 1'b0) begin
      errors++;
      $display("FAIL upd_hold got rdy=%b tk=%b want rdy=0 tk=0",
               cfg_ready, tick[0]);
    end
    step();
    checks++;
    if (cfg_ready !== 1'b1 || tick[0] !== 1'b1) begin
      errors++;
      $display("FAIL upd_wrap got rdy=%b tk=%b want rdy=1 tk=1",
               cfg_ready, tick[0]);
    end
    for (int k = 0; k < 8; k++) begin
      step();
      checks++;
      if (slow_clk[0] !== sc_e[k][0] || tick[0] !== tk_e[k][0]) begin
        errors++;
        $display("FAIL upd_slow step %0d got sc=%b tk=%b want sc=%0d tk=%0d",
                 k + 1, slow_clk[0], tick[0], sc_e[k], tk_e[k]);
      end
    end
  endtask

  task automatic test_sync();
    int sc0[8] = '{0, 1, 1, 0, 0, 1, 1, 0};
    int tk0[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    int sc1[8] = '{0, 1, 0, 1, 1, 0, 1, 0};
    int tk1[8] = '{0, 0, 1, 0, 0, 1, 0, 1};
    enable = 3'b000;
    sync = 1'b1; cfg_valid = 1'b1;
    cfg_chan = 2'd0; cfg_inc = 8'd64;
    step();
    cfg_chan = 2'd1; cfg_inc = 8'd96;
    step();
    sync = 1'b0; cfg_valid = 1'b0;
    enable = 3'b011;
    for (int k = 0; k < 7; k++) begin
      step();
      if (k == 2) begin
        checks++;
        if (tick[1:0] !== 2'b10) begin
          errors++;
          $display("FAIL pre_sync_tick got %b want 10", tick[1:0]);
        end
      end
    end
    sync = 1'b1;
    step();
    sync = 1'b0;
    checks++;
    if (slow_clk[1:0] !== 2'b00 || tick[1:0] !== 2'b00) begin
      errors++;
      $display("FAIL sync_zero got sc=%b tk=%b want sc=00 tk=00",
               slow_clk[1:0], tick[1:0]);
    end
    for (int k = 0; k < 8; k++) begin
      step();
      checks++;
      if (slow_clk[0] !== sc0[k][0] || tick[0] !== tk0[k][0] ||
          slow_clk[1] !== sc1[k][0] || tick[1] !== tk1[k][0]) begin
        errors++;
        $display("FAIL post_sync step %0d got sc=%b tk=%b want sc=%0d%0d tk=%0d%0d",
                 k + 1, slow_clk[1:0], tick[1:0],
                 sc1[k], sc0[k], tk1[k], tk0[k]);
      end
    end
  endtask

  task automatic test_enable();
    int sc1[10] = '{0, 1, 1, 0, 1, 0, 0, 1, 0, 1};
    int tk1[10] = '{1, 0, 0, 1, 0, 1, 0, 0, 1, 0};
    int sc0[4]  = '{1, 0, 0, 1};
    int tk0[4]  = '{0, 1, 0, 0};
    step();
    step();
    checks++;
    if (slow_clk[1:0] !== 2'b11) begin
      errors++;
      $display("FAIL en_pre got %b want 11", slow_clk[1:0]);
    end
    enable = 3'b010;
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if (slow_clk[0] !== 1'b1 || tick[0] !== 1'b0 ||
          slow_clk[1] !== sc1[k][0] || tick[1] !== tk1[k][0]) begin
        errors++;
        $display("FAIL en_off step %0d got sc=%b tk=%b want sc=%0d1 tk=%0d0",
                 k + 1, slow_clk[1:0], tick[1:0], sc1[k], tk1[k]);
      end
    end
    enable = 3'b011;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (slow_clk[0] !== sc0[k][0] || tick[0] !== tk0[k][0]) begin
        errors++;
        $display("FAIL en_resume step %0d got sc=%b tk=%b want sc=%0d tk=%0d",
                 k + 1, slow_clk[0], tick[0], sc0[k], tk0[k]);
      end
    end
  endtask

  task automatic test_async_reset();
    int nt;
    nt = 0;
    #3;
    checks++;
    if (slow_clk[0] !== 1'b1) begin
      errors++;
      $display("FAIL ares_pre got %b want 1", slow_clk[0]);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (slow_clk !== 3'b000 || tick !== 3'b000) begin
      errors++;
      $display("FAIL ares_now got sc=%b tk=%b want 000/000", slow_clk, tick);
    end
    #2;
    reset = 1'b0;
    enable = 3'b001;
    cfg_chan = 2'd1;
    #1;
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL ares_ready got %b want 1", cfg_ready);
    end
    for (int k = 1; k <= 256; k++) begin
      step();
      if (tick[0] === 1'b1) nt++;
      if (k == 127 || k == 128) begin
        checks++;
        if (slow_clk[0] !== (k == 128)) begin
          errors++;
          $display("FAIL dflt_slow step %0d got %b want %0d",
                   k, slow_clk[0], k == 128);
        end
      end
    end
    checks++;
    if (tick[0] !== 1'b1 || nt != 1) begin
      errors++;
      $display("FAIL dflt_tick got last=%b count=%0d want 1/1", tick[0], nt);
    end
  endtask

  task automatic test_out_of_range();
    int nt0;
    int nt1;
    int nsc;
    nt0 = 0; nt1 = 0; nsc = 0;
    cfg_valid = 1'b1; cfg_chan = 2'd3; cfg_inc = 8'd0;
    #1;
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL oor_ready got %b want 1", cfg_ready);
    end
    step();
    cfg_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      cfg_chan = 2'(c);
      #1;
      checks++;
      if (cfg_ready !== 1'b1) begin
        errors++;
        $display("FAIL oor_nopend ch%0d got %b want 1", c, cfg_ready);
      end
    end
    sync = 1'b1; cfg_valid = 1'b1;
    cfg_chan = 2'd0; cfg_inc = 8'd0;
    step();
    sync = 1'b0; cfg_valid = 1'b0;
    enable = 3'b011;
    for (int k = 0; k < 300; k++) begin
      step();
      if (tick[0] === 1'b1) nt0++;
      if (slow_clk[0] !== 1'b0) nsc++;
      if (tick[1] === 1'b1) nt1++;
    end
    checks++;
    if (nt0 != 0 || nsc != 0) begin
      errors++;
      $display("FAIL zero_inc got ticks=%0d highs=%0d want 0/0", nt0, nsc);
    end
    checks++;
    if (nt1 != 1) begin
      errors++;
      $display("FAIL ch1_dflt got ticks=%0d want 1", nt1);
    end
  endtask

  initial begin
    reset     = 1'b1;
    enable    = 3'b000;
    sync      = 1'b0;
    cfg_valid = 1'b0;
    cfg_chan  = 2'd0;
    cfg_inc   = 8'd0;
    test_reset();
    test_basic();
    test_cfg_update();
    test_sync();
    test_enable();
    test_async_reset();
    test_out_of_range();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
